// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port 1 arbiter.
// Load/store type codes and memory sizing stay in the common defs header.
package dmem_port_arbiter_pkg;

  typedef logic [3:0] mem_type_t;

  // Which requester issued the read whose data returns next cycle.
  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side and memory-side bundles for the port 1 arbiter.
// The requester bundle carries a full access request plus its grant and load return.
import dmem_port_arbiter_pkg::*;

interface dmem_req_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  mem_type_t         loadtype;
  mem_type_t         storetype;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, loadtype, storetype,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, loadtype, storetype,
    output gnt, rvalid, rdata
  );
endinterface

interface dmem_mem_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              read_en;
  logic              write_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  mem_type_t         loadtype;
  mem_type_t         storetype;
  logic [DATA_W-1:0] rdata;

  // The arbiter is the master; DataMemory port 1 is the slave.
  modport master (
    output read_en, write_en, addr, wdata, loadtype, storetype,
    input  rdata
  );

  modport slave (
    input  read_en, write_en, addr, wdata, loadtype, storetype,
    output rdata
  );
endinterface

// File: rtl/dmem_port_arbiter_req_mux.sv
// Combinational field mux: forwards the granted requester's access fields,
// or all zeros when nobody holds the grant.
import dmem_port_arbiter_pkg::*;

module dmem_req_mux #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              a_sel,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  mem_type_t         a_loadtype,
  input  mem_type_t         a_storetype,
  input  logic              b_sel,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  mem_type_t         b_loadtype,
  input  mem_type_t         b_storetype,
  output logic              active,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output mem_type_t         loadtype,
  output mem_type_t         storetype
);

  always_comb begin
    active    = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wdata     = '0;
    loadtype  = '0;
    storetype = '0;
    if (a_sel) begin
      active    = 1'b1;
      we        = a_we;
      addr      = a_addr;
      wdata     = a_wdata;
      loadtype  = a_loadtype;
      storetype = a_storetype;
    end else if (b_sel) begin
      active    = 1'b1;
      we        = b_we;
      addr      = b_addr;
      wdata     = b_wdata;
      loadtype  = b_loadtype;
      storetype = b_storetype;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares DataMemory port 1 between the core LSU (A) and the DMA/debug loader (B):
// fixed priority to A, a starvation guard for B, and routing of load data to its issuer.
import dmem_port_arbiter_pkg::*;

module dmem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clock1,
  input logic         rst,
  dmem_req_if.slave   a,
  dmem_req_if.slave   b,
  dmem_mem_if.master  mem
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             rd_pend;
  owner_e           rd_owner;

  logic b_force;
  logic a_gnt;
  logic b_gnt;
  logic sel_active;
  logic sel_we;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Grant is combinational from the live requests and the denial count.
  always_comb begin
    b_force = b.req && (starve_cnt == CNT_MAX);
    a_gnt   = a.req && !rst && !b_force;
    b_gnt   = b.req && !rst && !a_gnt;
  end

  assign a.gnt = a_gnt;
  assign b.gnt = b_gnt;

  dmem_req_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .a_sel       (a_gnt),
    .a_we        (a.we),
    .a_addr      (a.addr),
    .a_wdata     (a.wdata),
    .a_loadtype  (a.loadtype),
    .a_storetype (a.storetype),
    .b_sel       (b_gnt),
    .b_we        (b.we),
    .b_addr      (b.addr),
    .b_wdata     (b.wdata),
    .b_loadtype  (b.loadtype),
    .b_storetype (b.storetype),
    .active      (sel_active),
    .we          (sel_we),
    .addr        (mem.addr),
    .wdata       (mem.wdata),
    .loadtype    (mem.loadtype),
    .storetype   (mem.storetype)
  );

  assign mem.read_en  = sel_active && !sel_we;
  assign mem.write_en = sel_active && sel_we;

  // Issue stage -> return stage: remember whether a read went out and for whom.
  always_ff @(posedge clock1 or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= OWNER_A;
    end else begin
      rd_pend  <= mem.read_en;
      rd_owner <= b_gnt ? OWNER_B : OWNER_A;
      if (b.req && !b_gnt) begin
        starve_cnt <= sat_inc(starve_cnt);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign a.rvalid = rd_pend && (rd_owner == OWNER_A);
  assign b.rvalid = rd_pend && (rd_owner == OWNER_B);
  assign a.rdata  = a.rvalid ? mem.rdata : '0;
  assign b.rdata  = b.rvalid ? mem.rdata : '0;

  grant_onehot: assert property (@(posedge clock1) disable iff (rst) !(a_gnt && b_gnt));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized two-requester traffic,
// compared every cycle against a behavioural model with its own byte-array memory.
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int LIMIT  = 4;
  localparam int MEM_BYTES = 256;

  localparam logic [3:0] LD_B = 4'd0, LD_H = 4'd1, LD_W = 4'd2, LD_D = 4'd3;
  localparam logic [3:0] LD_BU = 4'd4, LD_HU = 4'd5, LD_WU = 4'd6;
  localparam logic [3:0] ST_B = 4'd0, ST_H = 4'd1, ST_W = 4'd2, ST_D = 4'd3;

  logic clock1 = 1'b0;
  logic rst = 1'b0;
  always #5 clock1 = ~clock1;

  dmem_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
  dmem_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();
  dmem_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  dmem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock1 (clock1),
    .rst    (rst),
    .a      (a_if),
    .b      (b_if),
    .mem    (mem_if)
  );

  function automatic logic [63:0] ext(input logic [63:0] raw, input logic [3:0] t);
    case (t)
      LD_B:    return {{56{raw[7]}}, raw[7:0]};
      LD_H:    return {{48{raw[15]}}, raw[15:0]};
      LD_W:    return {{32{raw[31]}}, raw[31:0]};
      LD_D:    return raw;
      LD_BU:   return {56'd0, raw[7:0]};
      LD_HU:   return {48'd0, raw[15:0]};
      LD_WU:   return {32'd0, raw[31:0]};
      default: return 64'd0;
    endcase
  endfunction

  function automatic int st_bytes(input logic [3:0] t);
    case (t)
      ST_B: return 1;
      ST_H: return 2;
      ST_W: return 4;
      ST_D: return 8;
      default: return 0;
    endcase
  endfunction

  // Stand-in for DataMemory port 1: registered read data, writes at the edge.
  logic [7:0] stub_mem [MEM_BYTES];
  bit filled = 1'b0;
  always @(posedge clock1) begin : stub
    logic [63:0] raw;
    if (!filled) begin
      for (int i = 0; i < MEM_BYTES; i++) stub_mem[i] <= 8'(i * 29 + 7);
      filled <= 1'b1;
    end else begin
      if (mem_if.read_en) begin
        raw = '0;
        for (int i = 0; i < 8; i++) raw[i*8 +: 8] = stub_mem[8'(mem_if.addr + 64'(i))];
        mem_if.rdata <= ext(raw, mem_if.loadtype);
      end
      if (mem_if.write_en)
        for (int i = 0; i < st_bytes(mem_if.storetype); i++)
          stub_mem[8'(mem_if.addr + 64'(i))] <= mem_if.wdata[i*8 +: 8];
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [MEM_BYTES];
  int          m_cnt = 0;
  bit          m_pend = 1'b0;
  bit          m_owner_b = 1'b0;
  logic [63:0] m_data = '0;
  bit          m_ga = 1'b0, m_gb = 1'b0;

  int checks = 0;
  int errors = 0;

  bit          seen_a_gnt, seen_b_gnt, seen_rd_en, seen_wr_en, seen_a_rv, seen_b_rv;
  logic [63:0] seen_a_rd, seen_b_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_pend = 1'b0;
    m_owner_b = 1'b0;
    m_ga = 1'b0;
    m_gb = 1'b0;
  endtask

  task automatic drive(input bit is_b, input bit req, input bit we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [3:0] lt, input logic [3:0] st);
    if (is_b) begin
      b_if.req = req; b_if.we = we; b_if.addr = addr;
      b_if.wdata = wdata; b_if.loadtype = lt; b_if.storetype = st;
    end else begin
      a_if.req = req; a_if.we = we; a_if.addr = addr;
      a_if.wdata = wdata; a_if.loadtype = lt; a_if.storetype = st;
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step(input bit rst_mid);
    bit ea, eb, f, sw;
    logic [63:0] sa, sd, raw;
    logic [3:0] sl, ss;
    @(negedge clock1);
    f  = b_if.req && (m_cnt == LIMIT);
    ea = a_if.req && !rst && !f;
    eb = b_if.req && !rst && !ea;
    sw = 1'b0; sa = '0; sd = '0; sl = '0; ss = '0;
    if (ea) begin
      sw = a_if.we; sa = a_if.addr; sd = a_if.wdata; sl = a_if.loadtype; ss = a_if.storetype;
    end else if (eb) begin
      sw = b_if.we; sa = b_if.addr; sd = b_if.wdata; sl = b_if.loadtype; ss = b_if.storetype;
    end
    chk("a_gnt", 64'(a_if.gnt), 64'(ea));
    chk("b_gnt", 64'(b_if.gnt), 64'(eb));
    chk("mem_read_en", 64'(mem_if.read_en), 64'((ea || eb) && !sw));
    chk("mem_write_en", 64'(mem_if.write_en), 64'((ea || eb) && sw));
    chk("mem_addr", mem_if.addr, sa);
    chk("mem_wdata", mem_if.wdata, sd);
    chk("mem_loadtype", 64'(mem_if.loadtype), 64'(sl));
    chk("mem_storetype", 64'(mem_if.storetype), 64'(ss));
    chk("a_rvalid", 64'(a_if.rvalid), 64'(m_pend && !m_owner_b));
    chk("b_rvalid", 64'(b_if.rvalid), 64'(m_pend && m_owner_b));
    chk("a_rdata", a_if.rdata, (m_pend && !m_owner_b) ? m_data : 64'd0);
    chk("b_rdata", b_if.rdata, (m_pend && m_owner_b) ? m_data : 64'd0);
    chk("starve_cnt", 64'(dut.starve_cnt), 64'(m_cnt));
    seen_a_gnt = a_if.gnt; seen_b_gnt = b_if.gnt;
    seen_rd_en = mem_if.read_en; seen_wr_en = mem_if.write_en;
    seen_a_rv = a_if.rvalid; seen_b_rv = b_if.rvalid;
    seen_a_rd = a_if.rdata; seen_b_rd = b_if.rdata;
    if (rst_mid) begin
      #1;
      rst = 1'b1;
      model_clear();
    end
    @(posedge clock1);
    if (rst) begin
      model_clear();
    end else begin
      m_ga = ea;
      m_gb = eb;
      m_pend = (ea || eb) && !sw;
      m_owner_b = eb;
      if (m_pend) begin
        for (int i = 0; i < 8; i++) raw[i*8 +: 8] = ref_mem[8'(sa + 64'(i))];
        m_data = ext(raw, sl);
      end
      if ((ea || eb) && sw)
        for (int i = 0; i < st_bytes(ss); i++) ref_mem[8'(sa + 64'(i))] = sd[i*8 +: 8];
      if (b_if.req && !eb) m_cnt = (m_cnt >= LIMIT) ? LIMIT : m_cnt + 1;
      else m_cnt = 0;
    end
    #1;
  endtask

  bit sa_g [6];
  bit sb_g [6];
  int pa, pb;

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i * 29 + 7);
    drive(0, 1, 0, 64'd16, 64'd0, LD_D, ST_D);
    drive(1, 1, 1, 64'd40, 64'h55, LD_D, ST_D);
    #1 rst = 1'b1;

    // Reset holds everything quiet even with both requests high.
    for (int i = 0; i < 3; i++) step(0);
    chk("rst_a_gnt", 64'(seen_a_gnt), 64'd0);
    chk("rst_b_gnt", 64'(seen_b_gnt), 64'd0);
    chk("rst_rd_en", 64'(seen_rd_en), 64'd0);
    chk("rst_wr_en", 64'(seen_wr_en), 64'd0);
    chk("rst_rvalid", 64'(seen_a_rv | seen_b_rv), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0);

    // A stores a doubleword, then loads it back.
    drive(0, 1, 1, 64'd16, 64'h1122334455667788, LD_D, ST_D);
    step(0);
    chk("st_a_gnt", 64'(seen_a_gnt), 64'd1);
    chk("st_wr_en", 64'(seen_wr_en), 64'd1);
    drive(0, 1, 0, 64'd16, 64'd0, LD_D, ST_D);
    step(0);
    chk("ld_a_gnt", 64'(seen_a_gnt), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step(0);
    chk("ld_a_rvalid", 64'(seen_a_rv), 64'd1);
    chk("ld_a_rdata", seen_a_rd, 64'h1122334455667788);
    chk("ld_b_rvalid", 64'(seen_b_rv), 64'd0);

    // B plants 0x80 at byte 8, then loads it signed and unsigned.
    drive(1, 1, 1, 64'd8, 64'h80, LD_B, ST_B);
    step(0);
    drive(1, 1, 0, 64'd8, 64'd0, LD_B, ST_B);
    step(0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(0);
    chk("sx_b_rvalid", 64'(seen_b_rv), 64'd1);
    chk("sx_b_rdata", seen_b_rd, 64'hFFFFFFFFFFFFFF80);
    drive(1, 1, 0, 64'd8, 64'd0, LD_BU, ST_B);
    step(0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(0);
    chk("zx_b_rvalid", 64'(seen_b_rv), 64'd1);
    chk("zx_b_rdata", seen_b_rd, 64'h80);

    // Starvation: both held from cycle 0, B forced through in cycle 4.
    drive(0, 1, 0, 64'd0, 64'd0, LD_D, ST_D);
    drive(1, 1, 0, 64'd24, 64'd0, LD_D, ST_D);
    for (int c = 0; c < 6; c++) begin
      step(0);
      sa_g[c] = seen_a_gnt;
      sb_g[c] = seen_b_gnt;
      if (seen_b_gnt) drive(1, 0, 0, 0, 0, 0, 0);
    end
    for (int c = 0; c < 4; c++) chk($sformatf("starve_b_gnt_c%0d", c), 64'(sb_g[c]), 64'd0);
    chk("starve_b_gnt_c4", 64'(sb_g[4]), 64'd1);
    chk("starve_a_gnt_c4", 64'(sa_g[4]), 64'd0);
    chk("starve_a_gnt_c5", 64'(sa_g[5]), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step(0);

    // Interleaved ownership: A load in N, B load in N+1.
    drive(0, 1, 0, 64'd16, 64'd0, LD_D, ST_D);
    step(0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 64'd8, 64'd0, LD_BU, ST_B);
    step(0);
    chk("il_a_rvalid", 64'(seen_a_rv), 64'd1);
    chk("il_a_rdata", seen_a_rd, 64'h1122334455667788);
    chk("il_b_rdata_n1", seen_b_rd, 64'd0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(0);
    chk("il_b_rvalid", 64'(seen_b_rv), 64'd1);
    chk("il_b_rdata", seen_b_rd, 64'h80);
    chk("il_a_rdata_n2", seen_a_rd, 64'd0);

    // Reset rising during a granted load (B also waiting).
    drive(0, 1, 0, 64'd16, 64'd0, LD_D, ST_D);
    drive(1, 1, 0, 64'd24, 64'd0, LD_D, ST_D);
    step(1);
    chk("rm_a_gnt", 64'(seen_a_gnt), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(0);
    chk("rm_a_rvalid_rst", 64'(seen_a_rv), 64'd0);
    rst = 1'b0;
    step(0);
    chk("rm_a_rvalid_after", 64'(seen_a_rv), 64'd0);
    chk("rm_starve_cnt", 64'(dut.starve_cnt), 64'd0);

    // Random traffic obeying hold-until-grant, with rare mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      pa = (n < 1500) ? 70 : 30;
      pb = (n < 1500) ? 50 : 90;
      if (!a_if.req || m_ga)
        drive(0, ($urandom % 100) < pa, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              4'($urandom_range(0, 6)), 4'($urandom_range(0, 3)));
      if (!b_if.req || m_gb)
        drive(1, ($urandom % 100) < pb, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              4'($urandom_range(0, 6)), 4'($urandom_range(0, 3)));
      if (rst) rst = 1'b0;
      step(($urandom % 200) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
